// File: rtl/info_pkg.sv
// info_pkg
// Shared types and constants for the slot-info change monitor.
//   - p2s_state_e : reset-pulse FSM states
//   - FLD_*       : field index of each packed slot-info field (field 0 in LSBs)
//   - DEF_*       : default parameter values for the monitor
package info_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } p2s_state_e;

    localparam int FLD_LDPC = 0;
    localparam int FLD_SLOT = 1;
    localparam int FLD_GEAR = 2;

    localparam int DEF_N_FIELDS  = 3;
    localparam int DEF_FIELD_W   = 8;
    localparam int DEF_STABLE_N  = 3;
    localparam int DEF_PULSE_LEN = 4;
    localparam int DEF_HOLDOFF   = 16;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/info_stab_filter.sv
// info_stab_filter
// Qualifies a sampled word over STABLE_N consecutive identical valid samples.
// Ports:
//   clk100m    in   clock
//   rst_100m   in   synchronous active-high reset
//   i_vld      in   sample strobe
//   i_data     in   sampled word
//   o_acc      out  combinational accept, high on the valid cycle the
//                   candidate becomes stable
//   o_acc_word out  word being accepted (valid with o_acc)
module info_stab_filter
    import info_pkg::*;
#(
    parameter int W        = 24,
    parameter int STABLE_N = DEF_STABLE_N
) (
    input  logic         clk100m,
    input  logic         rst_100m,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    output logic         o_acc,
    output logic [W-1:0] o_acc_word
);

    localparam int ST_W = $clog2(STABLE_N + 1);
    localparam logic [ST_W-1:0] STAB_MAX = ST_W'(STABLE_N);
    localparam logic [ST_W-1:0] STAB_PRE = ST_W'(STABLE_N - 1);

    logic [W-1:0]    cand_q, cand_d;
    logic [ST_W-1:0] stab_q, stab_d;

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        o_acc  = 1'b0;
        if (i_vld) begin
            if (i_data != cand_q) begin
                cand_d = i_data;
                stab_d = ST_W'(1);
                // A fresh value is already stable when one sample suffices.
                o_acc  = (STABLE_N == 1);
            end else begin
                if (stab_q != STAB_MAX) begin
                    stab_d = stab_q + ST_W'(1);
                end
                // Fire only on the transition into STABLE_N, not while saturated.
                o_acc = (stab_q == STAB_PRE);
            end
        end
    end

    assign o_acc_word = cand_d;

    always_ff @(posedge clk100m) begin
        if (rst_100m) begin
            cand_q <= '0;
            stab_q <= '0;
        end else begin
            cand_q <= cand_d;
            stab_q <= stab_d;
        end
    end

endmodule

// File: rtl/info_change_monitor.sv
// info_change_monitor
// Publishes qualified slot-info words with per-field change flags and drives
// an active-low P2S reset pulse when a masked field changes.
// Ports:
//   clk100m      in   clock
//   rst_100m     in   synchronous active-high reset
//   i_info_vld   in   sample strobe for i_info
//   i_info       in   packed slot info, field 0 in LSBs
//   i_rst_mask   in   per-field enable for reset-pulse generation
//   o_info       out  last accepted info word
//   o_info_vld   out  one-cycle pulse when o_info updates
//   o_chg_flags  out  per-field change of the latest update, held
//   o_p2s_rstn   out  active-low P2S reset
//   o_pulse_cnt  out  saturating count of issued reset pulses
//
// state | meaning
// IDLE  | no pulse in progress, o_p2s_rstn high
// PULSE | o_p2s_rstn low, pcnt counts down the remaining low cycles
// HOLD  | holdoff after a pulse, requests are remembered in pend
module info_change_monitor
    import info_pkg::*;
#(
    parameter int N_FIELDS  = DEF_N_FIELDS,
    parameter int FIELD_W   = DEF_FIELD_W,
    parameter int STABLE_N  = DEF_STABLE_N,
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                        clk100m,
    input  logic                        rst_100m,
    input  logic                        i_info_vld,
    input  logic [N_FIELDS*FIELD_W-1:0] i_info,
    input  logic [N_FIELDS-1:0]         i_rst_mask,
    output logic [N_FIELDS*FIELD_W-1:0] o_info,
    output logic                        o_info_vld,
    output logic [N_FIELDS-1:0]         o_chg_flags,
    output logic                        o_p2s_rstn,
    output logic [CNT_W-1:0]            o_pulse_cnt
);

    localparam int W    = N_FIELDS * FIELD_W;
    localparam int PC_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PULSE_LEN - 1);
    localparam logic [HC_W-1:0] HC_LOAD = (HOLDOFF > 0) ? HC_W'(HOLDOFF - 1) : '0;

    logic         acc;
    logic [W-1:0] acc_word;

    info_stab_filter #(
        .W        (W),
        .STABLE_N (STABLE_N)
    ) u_stab (
        .clk100m    (clk100m),
        .rst_100m   (rst_100m),
        .i_vld      (i_info_vld),
        .i_data     (i_info),
        .o_acc      (acc),
        .o_acc_word (acc_word)
    );

    logic [W-1:0]        info_q, info_d;
    logic                info_vld_q, info_vld_d;
    logic [N_FIELDS-1:0] chg_q, chg_d;
    logic                first_q, first_d;
    logic                req_q, req_d;
    p2s_state_e          state_q, state_d;
    logic [PC_W-1:0]     pcnt_q, pcnt_d;
    logic [HC_W-1:0]     hcnt_q, hcnt_d;
    logic                pend_q, pend_d;
    logic                rstn_q, rstn_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_FIELDS-1:0] diff;
    logic                upd;
    logic                cnt_inc;

    // Update path: a repeat of the published word is dropped unless nothing
    // has been published since reset.
    always_comb begin
        diff = '0;
        for (int k = 0; k < N_FIELDS; k++) begin
            diff[k] = (acc_word[k*FIELD_W +: FIELD_W] != info_q[k*FIELD_W +: FIELD_W]);
        end
        upd        = acc && (first_q || (acc_word != info_q));
        info_d     = info_q;
        info_vld_d = upd;
        chg_d      = chg_q;
        first_d    = first_q;
        req_d      = 1'b0;
        if (upd) begin
            info_d  = acc_word;
            first_d = 1'b0;
            chg_d   = first_q ? '1 : diff;
            req_d   = !first_q && ((diff & i_rst_mask) != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        hcnt_d  = hcnt_q;
        pend_d  = pend_q;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_q) begin
                    state_d = PULSE;
                    pcnt_d  = PC_LOAD;
                    cnt_inc = 1'b1;
                end
            end
            PULSE: begin
                if (req_q) begin
                    // Extend the running pulse; not counted as a new one.
                    pcnt_d = PC_LOAD;
                end else if (pcnt_q == '0) begin
                    if (HOLDOFF > 0) begin
                        state_d = HOLD;
                        hcnt_d  = HC_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    pcnt_d = pcnt_q - PC_W'(1);
                end
            end
            HOLD: begin
                if (hcnt_q == '0) begin
                    if (pend_q || req_q) begin
                        state_d = PULSE;
                        pcnt_d  = PC_LOAD;
                        cnt_inc = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hcnt_d = hcnt_q - HC_W'(1);
                    if (req_q) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d  = (cnt_inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        // Registered from the next state so the reset line is glitch-free.
        rstn_d = (state_d != PULSE);
    end

    always_ff @(posedge clk100m) begin
        if (rst_100m) begin
            info_q     <= '0;
            info_vld_q <= 1'b0;
            chg_q      <= '0;
            first_q    <= 1'b1;
            req_q      <= 1'b0;
            state_q    <= IDLE;
            pcnt_q     <= '0;
            hcnt_q     <= '0;
            pend_q     <= 1'b0;
            rstn_q     <= 1'b1;
            cnt_q      <= '0;
        end else begin
            info_q     <= info_d;
            info_vld_q <= info_vld_d;
            chg_q      <= chg_d;
            first_q    <= first_d;
            req_q      <= req_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            hcnt_q     <= hcnt_d;
            pend_q     <= pend_d;
            rstn_q     <= rstn_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_info      = info_q;
    assign o_info_vld  = info_vld_q;
    assign o_chg_flags = chg_q;
    assign o_p2s_rstn  = rstn_q;
    assign o_pulse_cnt = cnt_q;

endmodule

// File: doc/info_change_monitor.md
# info_change_monitor

Parametrised, single-clock successor to the slot-information clock-convert stage. It takes an already-synchronised packed slot-info word (gear / slot-time-switch id / LDPC id per slot) and qualifies each new value over consecutive valid samples. It publishes the accepted word with per-field change flags and drives an active-low P2S reset of programmable length whenever a masked field changes. It sits in the 100 MHz downlink domain, between the CDC FIFO read side and the P2S / LDPC consumers.

## Interface
Parameters:
- N_FIELDS, 3, number of packed fields; field 0 in the LSBs.
- FIELD_W, 8, width of each field.
- STABLE_N, 3, consecutive identical valid samples required to accept a value; legal values are 1 and above.
- PULSE_LEN, 4, width in cycles of the o_p2s_rstn low pulse; legal values are 1 and above.
- HOLDOFF, 16, cycles after a pulse during which no new pulse starts; 0 disables holdoff.
- CNT_W, 16, width of the pulse counter.

Ports:
- clk100m  in  1  sole clock.
- rst_100m  in  1  reset: synchronous and active-high.
- i_info_vld  in  1  sample strobe for i_info.
- i_info  in  N_FIELDS*FIELD_W  packed info. With default parameters: [23:16] gear, [15:8] slot id, [7:0] ldpc id.
- i_rst_mask  in  N_FIELDS  per-field enable for P2S reset generation; sampled on every accept.
- o_info  out  N_FIELDS*FIELD_W  last accepted info word.
- o_info_vld  out  1  one-cycle pulse when o_info updates.
- o_chg_flags  out  N_FIELDS  per-field difference of the latest update against the previous o_info; held until the next update.
- o_p2s_rstn  out  1  active-low P2S reset.
- o_pulse_cnt  out  CNT_W  saturating count of issued reset pulses.

## Operation
Stability filter:
- Holds a candidate word `cand` and a counter `stab`, which saturates at STABLE_N.
- On a cycle with i_info_vld and i_info==cand: stab increments.
- On a cycle with i_info_vld and i_info!=cand: cand<=i_info and stab<=1.
- Cycles without i_info_vld leave cand and stab unchanged.
- An accept fires on the valid cycle where stab reaches exactly STABLE_N. With STABLE_N=1, every valid sample that differs from cand, or that arrives while stab<1, is an accept.
- An accept is discarded if cand equals o_info, except for the first accept after reset.

Update on accept:
- o_info<=cand.
- o_info_vld pulses for one cycle.
- o_chg_flags[k] is set when field k differs from the previous o_info.
- The first accept after reset sets o_chg_flags to all ones and never requests a pulse (`first` flag).

Reset-pulse FSM, states IDLE, PULSE, HOLD:
- A request is raised by a non-first update where (o_chg_flags & i_rst_mask)!=0.
- IDLE + request -> PULSE; pcnt<=PULSE_LEN-1; o_pulse_cnt increments, saturating.
- PULSE: o_p2s_rstn=0. A new request restarts pcnt; this extends the current pulse, does not count as a new one, and does not increment o_pulse_cnt. When pcnt reaches 0: go to HOLD if HOLDOFF>0, otherwise go to IDLE.
- HOLD: o_p2s_rstn=1. A request sets `pend`. When hcnt reaches 0: if pend, go to PULSE (count +1, clear pend), otherwise go to IDLE.
- o_p2s_rstn=1 in IDLE and HOLD.

## Timing
- Reset values: o_info=0, o_info_vld=0, o_chg_flags=0, o_p2s_rstn=1, o_pulse_cnt=0. Internal: cand=0, stab=0, state IDLE, first=1, pend=0.
- Reset takes effect on the clock edge where rst_100m=1. Asserting it mid-pulse forces o_p2s_rstn=1 on the next cycle.
- An accept on cycle t produces o_info, o_info_vld and o_chg_flags at t+1.
- o_p2s_rstn first goes low at t+2 and stays low for exactly PULSE_LEN cycles unless the pulse is extended.
- Minimum spacing between two pulse starts is PULSE_LEN+HOLDOFF cycles.
- Valid samples may arrive back-to-back on every cycle. There is no backpressure.

## Structure
- Package info_pkg holds:
  - the FSM state enum (IDLE/PULSE/HOLD);
  - field index constants: FLD_LDPC=0, FLD_SLOT=1, FLD_GEAR=2;
  - default width constants.
- Sub-module info_stab_filter contains cand, stab and accept generation, parametrised by width and STABLE_N.
- The top level contains the update registers, the FSM and the pulse counter.

## Test plan
All scenarios use defaults unless stated.
- Reset release, then 3 valid samples of 0x021005 -> o_info=0x021005, o_chg_flags=3'b111, o_p2s_rstn stays 1, o_pulse_cnt=0.
- After that, 0x031005 ×3 with mask=3'b100 -> o_chg_flags=3'b100; rstn low for exactly 4 cycles starting 2 cycles after the 3rd sample; o_pulse_cnt=1.
- Glitch sequence 0x031006, 0x031005, 0x031006, 0x031006 -> no accept, o_info unchanged, no o_info_vld.
- With mask=3'b100: 0x031007 ×3 -> o_chg_flags=3'b001, o_info_vld pulses, rstn stays 1.
- Gear change during HOLD (0x041007, 5 cycles after the pulse ends) -> second pulse starts exactly 16 cycles after the first ends; o_pulse_cnt=2.
- rst_100m asserted on the 2nd low cycle of a pulse -> rstn=1 on the next cycle, all outputs at reset values. The next valid triple updates o_info with no pulse.
